// File: rtl/booth_sequencer.sv
// ---------------------------------------------------------------------------
// booth_sequencer
//
// Control sequencer for a radix-2 Booth multiplier datapath. It accepts a
// two's-complement operand pair over a valid/ready handshake, registers it
// onto the datapath operand buses, and issues one LOAD strobe. It then issues
// OP_W ADDSUB/SHIFT strobe pairs, captures the datapath {accumulator,
// multiplier} registers as the product, and presents that product over a
// second valid/ready handshake.
//
// Parameters
//   OP_W          operand width; the product is 2*OP_W bits
//
// Compile-time options
//   ZERO_BYPASS_EN  when defined, an accept with either operand equal to zero
//                   skips the datapath and goes straight to DONE with a zero
//                   product. This path issues no strobes.
//
// Ports
//   clk           single clock, rising edge
//   rst_n         asynchronous active-low reset
//   in_valid      operand pair offered
//   in_ready      sequencer can accept (high only in IDLE)
//   op_a, op_b    multiplicand / multiplier (two's complement)
//   input_1/2     registered multiplicand / multiplier to the datapath
//   load          datapath load strobe (LOAD state)
//   sum_or_diff   datapath add/subtract strobe (ADDSUB state)
//   shift         datapath arithmetic-shift strobe (SHIFT state)
//   shmnt         arithmetic shift amount (1 in SHIFT, 0 elsewhere)
//   dxb_input_1/2 datapath accumulator / multiplier registers
//   product       registered result
//   out_valid     product valid (DONE state)
//   out_ready     consumer accepts product
// ---------------------------------------------------------------------------
module booth_sequencer #(
    parameter int OP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op_a,
    input  logic [OP_W-1:0]   op_b,

    output logic [OP_W-1:0]   input_1,
    output logic [OP_W-1:0]   input_2,
    output logic              load,
    output logic              sum_or_diff,
    output logic              shift,
    output logic [3:0]        shmnt,
    input  logic [OP_W-1:0]   dxb_input_1,
    input  logic [OP_W-1:0]   dxb_input_2,

    output logic [2*OP_W-1:0] product,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int CNT_W = $clog2(OP_W) + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ADDSUB,
        SHIFT,
        CAPTURE,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] iter_cnt;
    logic             accept;
    logic             last_iter;

    // in_ready is a pure state decode, so an accept can only happen in IDLE.
    // Because of that, in_valid is ignored everywhere else.
    assign accept    = in_valid && in_ready;

    // The counter holds the number of SHIFTs already completed. The SHIFT that
    // sees OP_W-1 is therefore the OP_W-th and last one.
    assign last_iter = (iter_cnt >= CNT_W'(OP_W - 1));

`ifdef ZERO_BYPASS_EN
    logic zero_op;
    assign zero_op = (op_a == '0) || (op_b == '0);
`endif

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: every register in this block is clocked state, so it is written
    // with non-blocking assignments only. This keeps all registers sampling
    // the same pre-edge values, whatever order the processes run in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and Moore outputs
    // -----------------------------------------------------------------------
    // NOTE: every output of this block gets a default before the case. As a
    // result, no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        load        = 1'b0;
        sum_or_diff = 1'b0;
        shift       = 1'b0;
        shmnt       = 4'd0;
        out_valid   = 1'b0;

        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) begin
`ifdef ZERO_BYPASS_EN
                    state_nxt = zero_op ? DONE : LOAD;
`else
                    state_nxt = LOAD;
`endif
                end
            end

            LOAD: begin
                load      = 1'b1;
                state_nxt = ADDSUB;
            end

            ADDSUB: begin
                sum_or_diff = 1'b1;
                state_nxt   = SHIFT;
            end

            SHIFT: begin
                shift     = 1'b1;
                shmnt     = 4'd1;
                state_nxt = last_iter ? CAPTURE : ADDSUB;
            end

            CAPTURE: begin
                state_nxt = DONE;
            end

            DONE: begin
                out_valid = 1'b1;
                // out_ready matters only here. The handshake edge returns the
                // FSM to IDLE, and in_ready rises one cycle later. So an
                // accept never lands on the same edge as the output
                // handshake.
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Operand registers: loaded only on accept. Later changes on op_a/op_b
    // cannot reach the datapath during an operation.
    // -----------------------------------------------------------------------
    // NOTE: these are control-visible datapath registers, not storage arrays.
    // They take the asynchronous reset so that the datapath buses come out of
    // reset at a known zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            input_1 <= '0;
            input_2 <= '0;
        end else if (accept) begin
            input_1 <= op_a;
            input_2 <= op_b;
        end
    end

    // -----------------------------------------------------------------------
    // Iteration counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter_cnt <= '0;
        end else if (state == LOAD) begin
            iter_cnt <= '0;
        end else if (state == SHIFT) begin
            iter_cnt <= iter_cnt + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Product register. It changes only when CAPTURE samples the datapath,
    // or, with the bypass built in, on a zero-operand accept.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product <= '0;
        end else if (state == CAPTURE) begin
            product <= {dxb_input_1, dxb_input_2};
`ifdef ZERO_BYPASS_EN
        end else if (accept && zero_op) begin
            product <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_booth_sequencer.sv
module tb_booth_sequencer;

    localparam int OP_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   op_a;
    logic [OP_W-1:0]   op_b;
    logic [OP_W-1:0]   input_1;
    logic [OP_W-1:0]   input_2;
    logic              load;
    logic              sum_or_diff;
    logic              shift;
    logic [3:0]        shmnt;
    logic [OP_W-1:0]   dxb_input_1;
    logic [OP_W-1:0]   dxb_input_2;
    logic [2*OP_W-1:0] product;
    logic              out_valid;
    logic              out_ready;

    int total = 0;
    int bad   = 0;

    booth_sequencer #(.OP_W(OP_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .input_1     (input_1),
        .input_2     (input_2),
        .load        (load),
        .sum_or_diff (sum_or_diff),
        .shift       (shift),
        .shmnt       (shmnt),
        .dxb_input_1 (dxb_input_1),
        .dxb_input_2 (dxb_input_2),
        .product     (product),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    // Radix-2 Booth datapath driven by the strobes. The accumulator is one
    // bit wider than the operand, so that -(-2^(OP_W-1)) does not overflow.
    logic [OP_W:0]          dp_acc;
    logic [OP_W-1:0]        dp_q;
    logic                   dp_q1;
    logic signed [2*OP_W+1:0] dp_cat;
    logic signed [2*OP_W+1:0] dp_sh;
    logic [OP_W:0]          dp_m;

    assign dp_m        = {input_1[OP_W-1], input_1};
    assign dp_cat      = {dp_acc, dp_q, dp_q1};
    assign dp_sh       = dp_cat >>> shmnt;
    assign dxb_input_1 = dp_acc[OP_W-1:0];
    assign dxb_input_2 = dp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_acc <= '0;
            dp_q   <= '0;
            dp_q1  <= 1'b0;
        end else if (load) begin
            dp_acc <= '0;
            dp_q   <= input_2;
            dp_q1  <= 1'b0;
        end else if (sum_or_diff) begin
            case ({dp_q[0], dp_q1})
                2'b10:   dp_acc <= dp_acc - dp_m;
                2'b01:   dp_acc <= dp_acc + dp_m;
                default: dp_acc <= dp_acc;
            endcase
        end else if (shift) begin
            {dp_acc, dp_q, dp_q1} <= dp_sh;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for in_ready, offers (a, b) and returns in cycle 1 after the
    // accept edge. The operands are then scrambled.
    task automatic issue(input string tag, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
        int n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        check({tag, "_ready_wait"}, 32'(n < 50), 32'd1);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        step();
        in_valid = 1'b0;
        op_a     = 8'hA5;
        op_b     = 8'h5A;
    endtask

    // Called in cycle 1. Runs to the first out_valid cycle, then checks the
    // latency, the strobe counts and the product. If out_ready is high, it
    // also completes the handshake.
    task automatic finish_op(input string tag, input logic [15:0] exp_prod,
                             input int exp_lat, input int exp_n);
        int cyc = 1;
        int n_ld = 0, n_sod = 0, n_sh = 0, n_multi = 0, n_shm = 0;
        while (!out_valid && cyc < 60) begin
            n_ld  += int'(load);
            n_sod += int'(sum_or_diff);
            n_sh  += int'(shift);
            if (int'(load) + int'(sum_or_diff) + int'(shift) > 1) n_multi++;
            if (shmnt !== (shift ? 4'd1 : 4'd0)) n_shm++;
            step();
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_load_cnt"}, 32'(n_ld), 32'(exp_n != 0 ? 1 : 0));
        check({tag, "_sod_cnt"}, 32'(n_sod), 32'(exp_n));
        check({tag, "_shift_cnt"}, 32'(n_sh), 32'(exp_n));
        check({tag, "_onehot"}, 32'(n_multi), 32'd0);
        check({tag, "_shmnt"}, 32'(n_shm), 32'd0);
        check({tag, "_product"}, 32'(product), 32'(exp_prod));
        check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        if (out_ready) begin
            step();
            check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
            check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        out_ready = 1'b0;

        // Reset values while rst_n is held low.
        #2;
        check("rst_input_1", 32'(input_1), 32'd0);
        check("rst_input_2", 32'(input_2), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_strobes", 32'({load, sum_or_diff, shift}), 32'd0);
        check("rst_shmnt", 32'(shmnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Signed products with the consumer always ready.
        out_ready = 1'b1;
        issue("m3x5", 8'd3, 8'd5);
        check("m3x5_load_c1", 32'(load), 32'd1);
        check("m3x5_input_1", 32'(input_1), 32'd3);
        check("m3x5_input_2", 32'(input_2), 32'd5);
        finish_op("m3x5", 16'h000F, 19, 8);

        issue("mn3x5", 8'hFD, 8'd5);                  // -3 * 5
        finish_op("mn3x5", 16'hFFF1, 19, 8);
        issue("mn128sq", 8'h80, 8'h80);               // -128 * -128
        finish_op("mn128sq", 16'h4000, 19, 8);
        issue("m127xn128", 8'h7F, 8'h80);             // 127 * -128
        finish_op("m127xn128", 16'hC080, 19, 8);

        // Consumer stall: hold out_ready low for 5 DONE cycles.
        out_ready = 1'b0;
        issue("stall", 8'd2, 8'hFF);                  // 2 * -1
        finish_op("stall", 16'hFFFE, 19, 8);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            op_a     = 8'd9;
            op_b     = 8'd9;
            step();
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_product", 32'(product), 32'hFFFE);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_no_load", 32'(load), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("stall_release_valid", 32'(out_valid), 32'd0);
        check("stall_release_ready", 32'(in_ready), 32'd1);
        check("stall_release_product", 32'(product), 32'hFFFE);

        // Reset asserted in cycle 9 of an operation.
        issue("abort", 8'd5, 8'd5);
        repeat (8) step();
        rst_n = 1'b0;
        #1;
        check("abort_input_1", 32'(input_1), 32'd0);
        check("abort_input_2", 32'(input_2), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_strobes", 32'({load, sum_or_diff, shift}), 32'd0);
        check("abort_shmnt", 32'(shmnt), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        op_a     = 8'd2;
        op_b     = 8'd7;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        step();
        check("abort_first_accept", 32'(load), 32'd1);
        in_valid = 1'b0;
        op_a     = 8'hA5;
        op_b     = 8'h5A;
        finish_op("m2x7", 16'h000E, 19, 8);

        // Zero operand.
        issue("zero", 8'd0, 8'd77);
`ifdef ZERO_BYPASS_EN
        finish_op("zero", 16'h0000, 1, 0);
`else
        finish_op("zero", 16'h0000, 19, 8);
`endif

        // Back-to-back with in_valid held high. The second accept comes one
        // cycle after the first output handshake.
        in_valid = 1'b1;
        op_a     = 8'd6;
        op_b     = 8'hF9;                              // 6 * -7
        step();
        check("b2b_first_load", 32'(load), 32'd1);
        begin
            int n = 0;
            while (!out_valid && n < 60) begin
                step();
                n++;
            end
            check("b2b_first_done", 32'(out_valid), 32'd1);
        end
        check("b2b_first_product", 32'(product), 32'hFFD6);
        step();                                       // handshake edge
        check("b2b_idle_ready", 32'(in_ready), 32'd1);
        check("b2b_idle_no_load", 32'(load), 32'd0);
        step();                                       // second accept edge
        check("b2b_second_load", 32'(load), 32'd1);
        in_valid = 1'b0;
        op_a     = 8'hA5;
        op_b     = 8'h5A;
        finish_op("b2b_second", 16'hFFD6, 19, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/booth_sequencer.md
BOOTH_SEQUENCER -- requirements
Module: booth_sequencer

Interface
REQ-001 The module SHALL have one parameter, OP_W, default 8, giving the operand width; the product is 2*OP_W bits.
REQ-002 The port clk SHALL be an input, 1 bit wide, and be the single clock; all registers update on its rising edge.
REQ-003 The port rst_n SHALL be an input, 1 bit wide, and be an asynchronous, active-low reset.
REQ-004 The port in_valid SHALL be an input, 1 bit wide, and indicate that an operand pair is offered.
REQ-005 The port in_ready SHALL be an output, 1 bit wide, and indicate that the sequencer can accept an operand pair.
REQ-006 The ports op_a and op_b SHALL be inputs, OP_W bits wide, and carry the two's-complement multiplicand and multiplier.
REQ-007 The ports input_1 and input_2 SHALL be outputs, OP_W bits wide, and drive the registered multiplicand and multiplier to the datapath.
REQ-008 The ports load, sum_or_diff and shift SHALL be outputs, 1 bit wide, and be the datapath control strobes.
REQ-009 The port shmnt SHALL be an output, 4 bits wide, and give the datapath arithmetic-shift amount.
REQ-010 The ports dxb_input_1 and dxb_input_2 SHALL be inputs, OP_W bits wide, and carry the datapath accumulator and multiplier registers.
REQ-011 The port product SHALL be an output, 2*OP_W bits wide, and hold the registered result.
REQ-012 The port out_valid SHALL be an output, 1 bit wide, and indicate that product is valid.
REQ-013 The port out_ready SHALL be an input, 1 bit wide, and indicate that the consumer accepts product.

Function
REQ-014 The FSM SHALL have the states IDLE, LOAD, ADDSUB, SHIFT, CAPTURE and DONE.
REQ-015 The block SHALL drive in_ready high only in IDLE.
REQ-016 An accept SHALL occur when in_valid and in_ready are both high at a clock edge; on accept, op_a and op_b are registered onto input_1 and input_2 and the state becomes LOAD.
REQ-017 The strobes SHALL be Moore outputs with exactly one high per cycle: load in LOAD, sum_or_diff in ADDSUB, shift in SHIFT.
REQ-018 shmnt SHALL be 4'd1 in SHIFT and 4'd0 in every other state.
REQ-019 The transitions SHALL be LOAD->ADDSUB and ADDSUB->SHIFT.
REQ-020 From SHIFT, the FSM SHALL go to ADDSUB while the iteration counter is below OP_W-1, and to CAPTURE otherwise.
REQ-021 The iteration counter SHALL clear in LOAD, increment in SHIFT, and be $clog2(OP_W)+1 bits wide.
REQ-022 In CAPTURE, product SHALL register {dxb_input_1, dxb_input_2}; the next state is DONE.
REQ-023 In DONE, out_valid SHALL be 1 and product SHALL stay stable until out_ready is high; that edge returns the FSM to IDLE.
REQ-024 in_ready SHALL rise one cycle after the DONE->IDLE edge; there is no accept in the same cycle as the output handshake.
REQ-025 Latency SHALL be fixed: with the accept at edge E0, LOAD is cycle 1, ADDSUB/SHIFT pairs occupy cycles 2..2*OP_W+1, CAPTURE is cycle 2*OP_W+2, and out_valid is high from cycle 2*OP_W+3 (cycle 19 for OP_W=8).
REQ-026 in_valid SHALL be ignored outside IDLE, and op_a/op_b changes after accept SHALL not affect the result.
REQ-027 out_ready SHALL be ignored outside DONE.
REQ-028 product SHALL hold its last value in every state except CAPTURE.

Reset
REQ-029 When rst_n is low, regardless of clk, the block SHALL go to IDLE, clear the counter, and drive input_1=0, input_2=0, product=0, out_valid=0, load=sum_or_diff=shift=0 and shmnt=0.
REQ-030 in_ready SHALL be 1 after reset deassertion.
REQ-031 A reset during any state SHALL abort the operation with no output handshake.
REQ-032 The first accept SHALL be possible at the first clock edge after rst_n rises.

Configuration
REQ-033 When ZERO_BYPASS_EN is defined, an accept with op_a==0 or op_b==0 SHALL go directly to DONE with product=0, out_valid high from cycle 1, and no load, sum_or_diff or shift strobes.
REQ-034 When ZERO_BYPASS_EN is undefined, zero operands SHALL take the full sequence with the REQ-025 latency, and product=0 is produced by the datapath.

Verification
REQ-035 The bench SHALL apply op_a=3, op_b=5 with out_ready=1 and check product=16'h000F with out_valid first high in cycle 19 and exactly 8 sum_or_diff and 8 shift pulses.
REQ-036 The bench SHALL apply op_a=-3, op_b=5 and check product=16'hFFF1; apply op_a=-128, op_b=-128 and check 16'h4000; apply op_a=127, op_b=-128 and check 16'hC080.
REQ-037 The bench SHALL hold out_ready=0 for 5 cycles in DONE and check that out_valid and product stay stable, in_ready stays 0, and a new in_valid is not accepted.
REQ-038 The bench SHALL assert rst_n=0 in cycle 9 of an operation and check that all outputs return to reset values immediately, in_ready=1 after release, and a fresh 2*7 completes correctly.
REQ-039 The bench SHALL apply op_a=0, op_b=77 and check product=0 with out_valid in cycle 1 and no strobes when ZERO_BYPASS_EN is defined, and in cycle 19 when it is undefined.
REQ-040 The bench SHALL issue back-to-back operations with in_valid held high and check that the second accept occurs one cycle after the first output handshake.
